// File: rtl/axo_mem_pkg.sv
// axo_mem shared types: arbiter state, bus error codes and a
// reference round-robin pick (req, last -> one-hot winner).
package axo_mem_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [31:0] AXO_MEM_EMISSING = 32'hE000_0001;
  localparam logic [31:0] AXO_MEM_ETIMEOUT = 32'hE000_0002;

  localparam int RR_MAX = 32;

  // Nearest requester after last wins; last itself comes last.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] req,
    input logic [RR_MAX-1:0] last,
    input int                n
  );
    logic [RR_MAX-1:0] pick;
    int li;
    int j;
    pick = '0;
    li   = n - 1;
    for (int i = 0; i < RR_MAX; i++)
      if (i < n && last[i]) li = i;
    for (int k = n; k >= 1; k--) begin
      j = (li + k) % n;
      if (req[j]) begin
        pick    = '0;
        pick[j] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axo_mem_bus.sv
// axo_mem_bus: single-transfer memory bus.
// CPU drives re/we/asize/addr/wdata; MEM returns rdata/ready/error.
interface axo_mem_bus #(
  parameter int dlen = 32,
  parameter int alen = 32
);
  logic            re;
  logic            we;
  logic [2:0]      asize;
  logic [alen-1:0] addr;
  logic [dlen-1:0] wdata;
  logic [dlen-1:0] rdata;
  logic            ready;
  logic            error;

  modport CPU (
    output re, we, asize, addr, wdata,
    input  rdata, ready, error
  );

  modport MEM (
    input  re, we, asize, addr, wdata,
    output rdata, ready, error
  );
endinterface

// File: rtl/axo_rr_pick.sv
// Combinational round-robin picker: req/last (one-hot) -> pick.
// Rotate req past last, isolate lowest bit, rotate back.
module axo_rr_pick #(
  parameter int n = 2
) (
  input  logic [n-1:0] req,
  input  logic [n-1:0] last,
  output logic [n-1:0] pick
);

  localparam int SW = $clog2(n);

  logic [SW-1:0]  sh;
  logic [2*n-1:0] rot2;
  logic [2*n-1:0] back2;
  logic [n-1:0]   rot;
  logic [n-1:0]   pe;

  always_comb begin
    // last at the top bit wraps to a zero shift
    sh = '0;
    for (int i = 0; i < n - 1; i++)
      if (last[i]) sh = SW'(i + 1);
    rot2  = {req, req} >> sh;
    rot   = rot2[n-1:0];
    pe    = rot & (-rot);
    back2 = {pe, pe} << sh;
    pick  = back2[2*n-1:n];
  end

endmodule

// File: rtl/axo_mem_rr_arbiter.sv
// Round-robin arbiter: cpu_ports[cpus] share mem_port, with watchdog.
// Outputs grant (one-hot), busy, timeout_evt; rst is sync active-low.
module axo_mem_rr_arbiter
  import axo_mem_pkg::*;
#(
  parameter int dlen    = 32,
  parameter int alen    = 32,
  parameter int cpus    = 2,
  parameter int timeout = 255
) (
  input  logic            clk,
  input  logic            rst,
  axo_mem_bus.MEM         cpu_ports [cpus],
  axo_mem_bus.CPU         mem_port,
  output logic [cpus-1:0] grant,
  output logic            busy,
  output logic            timeout_evt
);

  localparam bit WD_EN = (timeout > 0);
  localparam int WW    = WD_EN ? $clog2(timeout + 1) : 1;
  localparam logic [WW-1:0] W_TOP = WW'(timeout);
  localparam logic [WW-1:0] W_MAX = '1;
  localparam logic [dlen-1:0] ETMO = dlen'(AXO_MEM_ETIMEOUT);
  localparam logic [cpus-1:0] LAST_RST =
    {1'b1, {(cpus-1){1'b0}}};

  arb_state_e      state;
  logic [cpus-1:0] last;
  logic [cpus-1:0] pick;
  logic [WW-1:0]   wdog;

  logic [cpus-1:0] re_v;
  logic [cpus-1:0] we_v;
  logic [cpus-1:0] req;
  logic [2:0]      asize_v [cpus];
  logic [alen-1:0] addr_v  [cpus];
  logic [dlen-1:0] wdata_v [cpus];

  logic            req_g;
  logic            tmo_fire;
  logic [2:0]      m_asize;
  logic [alen-1:0] m_addr;
  logic [dlen-1:0] m_wdata;

  for (genvar i = 0; i < cpus; i++) begin : g_port
    assign re_v[i]    = cpu_ports[i].re;
    assign we_v[i]    = cpu_ports[i].we;
    assign asize_v[i] = cpu_ports[i].asize;
    assign addr_v[i]  = cpu_ports[i].addr;
    assign wdata_v[i] = cpu_ports[i].wdata;

    assign cpu_ports[i].ready =
      grant[i] & (tmo_fire | mem_port.ready);
    assign cpu_ports[i].error =
      grant[i] & (tmo_fire | mem_port.error);
    assign cpu_ports[i].rdata =
      (grant[i] && tmo_fire) ? ETMO : mem_port.rdata;
  end

  assign req   = re_v | we_v;
  assign req_g = |(req & grant);
  assign busy  = (state == ARB_BUSY);

  // mem ready in the same cycle beats the watchdog
  assign tmo_fire = WD_EN && busy && req_g &&
                    !mem_port.ready && (wdog == W_TOP);
  assign timeout_evt = tmo_fire;

  // grant is one-hot or zero, so an OR acts as the mux
  always_comb begin
    m_asize = '0;
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < cpus; i++)
      if (grant[i]) begin
        m_asize = m_asize | asize_v[i];
        m_addr  = m_addr  | addr_v[i];
        m_wdata = m_wdata | wdata_v[i];
      end
  end

  assign mem_port.re    = |(re_v & grant) & ~tmo_fire;
  assign mem_port.we    = |(we_v & grant) & ~tmo_fire;
  assign mem_port.asize = m_asize;
  assign mem_port.addr  = m_addr;
  assign mem_port.wdata = m_wdata;

  axo_rr_pick #(
    .n(cpus)
  ) u_pick (
    .req (req),
    .last(last),
    .pick(pick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= LAST_RST;
      wdog  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|req) begin
            state <= ARB_BUSY;
            grant <= pick;
            last  <= pick;
            wdog  <= '0;
          end
        end
        ARB_BUSY: begin
          // completion, abort or watchdog all end the turn
          if (!req_g || mem_port.ready || tmo_fire) begin
            state <= ARB_IDLE;
            grant <= '0;
          end else if (wdog != W_MAX) begin
            wdog <= wdog + WW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axo_mem_rr_arbiter.sv
// Bench for axo_mem_rr_arbiter (cpus=3, timeout=4).
// Vector table plus directed multi-cycle sequences.
module tb_axo_mem_rr_arbiter;
  import axo_mem_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axo_mem_bus #(.dlen(32), .alen(32)) cpu_if [N] ();
  axo_mem_bus #(.dlen(32), .alen(32)) mem_if ();

  logic [N-1:0] grant;
  logic         busy;
  logic         tevt;

  logic [N-1:0] cre = '0;
  logic [N-1:0] cwe = '0;
  logic [2:0]   casz   [N];
  logic [31:0]  caddr  [N];
  logic [31:0]  cwdata [N];
  logic [N-1:0] c_rdy;
  logic [N-1:0] c_err;
  logic [31:0]  c_rdata [N];

  logic        m_rdy   = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_rdata = '0;

  for (genvar i = 0; i < N; i++) begin : g_if
    assign cpu_if[i].re    = cre[i];
    assign cpu_if[i].we    = cwe[i];
    assign cpu_if[i].asize = casz[i];
    assign cpu_if[i].addr  = caddr[i];
    assign cpu_if[i].wdata = cwdata[i];
    assign c_rdy[i]   = cpu_if[i].ready;
    assign c_err[i]   = cpu_if[i].error;
    assign c_rdata[i] = cpu_if[i].rdata;
  end

  assign mem_if.ready = m_rdy;
  assign mem_if.error = m_err;
  assign mem_if.rdata = m_rdata;

  axo_mem_rr_arbiter #(
    .dlen(32), .alen(32), .cpus(N), .timeout(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ports  (cpu_if),
    .mem_port   (mem_if),
    .grant      (grant),
    .busy       (busy),
    .timeout_evt(tevt)
  );

  int checks   = 0;
  int failures = 0;
  logic mon = 1'b0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon) begin
      checks++;
      if (((grant & (grant - 3'd1)) != 3'd0) ||
          ((c_rdy & ~grant) != 3'd0) ||
          (!busy && (mem_if.re || mem_if.we))) begin
        failures++;
        $display("FAIL invariant actual=g%b r%b b%b required=onehot",
                 grant, c_rdy, busy);
      end
    end
  end

  typedef struct {
    logic       rst;
    logic [2:0] re;
    logic       mrdy;
    logic       merr;
    logic [2:0] g;
    logic       b;
    logic       mre;
    logic [2:0] rdy;
    logic [2:0] err;
    logic       te;
  } vec_t;

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < N; i++) begin
      casz[i]   = '0;
      caddr[i]  = '0;
      cwdata[i] = '0;
    end
    // reset held with everyone requesting
    tbl[0]  = '{0, 3'b111, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0};
    tbl[1]  = '{0, 3'b111, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0};
    tbl[2]  = '{0, 3'b111, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0};
    // fairness: mem always ready
    tbl[3]  = '{1, 3'b111, 1, 0, 3'b001, 1, 1, 3'b001, 3'b000, 0};
    tbl[4]  = '{1, 3'b111, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0};
    tbl[5]  = '{1, 3'b111, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000, 0};
    tbl[6]  = '{1, 3'b111, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0};
    tbl[7]  = '{1, 3'b111, 1, 0, 3'b100, 1, 1, 3'b100, 3'b000, 0};
    tbl[8]  = '{1, 3'b111, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0};
    tbl[9]  = '{1, 3'b111, 1, 0, 3'b001, 1, 1, 3'b001, 3'b000, 0};
    tbl[10] = '{1, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0};
    // abort: port0 drops, pending port1 follows
    tbl[11] = '{1, 3'b001, 0, 0, 3'b001, 1, 1, 3'b000, 3'b000, 0};
    tbl[12] = '{1, 3'b010, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0};
    tbl[13] = '{1, 3'b010, 1, 1, 3'b010, 1, 1, 3'b010, 3'b010, 0};
    tbl[14] = '{1, 3'b010, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0};

    for (int i = 0; i < 15; i++) begin
      rst   = tbl[i].rst;
      cre   = tbl[i].re;
      m_rdy = tbl[i].mrdy;
      m_err = tbl[i].merr;
      tick();
      mon = 1'b1;
      chk($sformatf("vec%0d", i),
          {grant, busy, mem_if.re, mem_if.we, c_rdy, c_err, tevt},
          {tbl[i].g, tbl[i].b, tbl[i].mre, 1'b0,
           tbl[i].rdy, tbl[i].err, tbl[i].te});
    end
    cre   = '0;
    m_rdy = 1'b0;
    m_err = 1'b0;

    // routing: port1 write, others carry junk fields
    caddr[0] = 32'hAAAA_0000; cwdata[0] = 32'h1111_1111; casz[0] = 3'd1;
    caddr[2] = 32'hBBBB_0000; cwdata[2] = 32'h2222_2222; casz[2] = 3'd3;
    caddr[1] = 32'h0000_1000; cwdata[1] = 32'hDEAD_BEEF; casz[1] = 3'd2;
    cwe = 3'b010;
    m_rdata = 32'h1234_5678;
    tick();
    chk("rt_grant", grant, 3'b010);
    chk("rt_bus",
        {mem_if.re, mem_if.we, mem_if.asize, mem_if.addr, mem_if.wdata},
        {1'b0, 1'b1, 3'd2, 32'h0000_1000, 32'hDEAD_BEEF});
    chk("rt_rdy_wait", c_rdy, 3'b000);
    tick();
    chk("rt_hold", {busy, grant}, {1'b1, 3'b010});
    m_rdy = 1'b1;
    #1;
    chk("rt_rdy", {c_rdy, c_err}, {3'b010, 3'b000});
    chk("rt_rdata0", c_rdata[0], 32'h1234_5678);
    tick();
    chk("rt_done", {busy, grant, mem_if.we}, {1'b0, 3'b000, 1'b0});
    cwe   = '0;
    m_rdy = 1'b0;

    // watchdog: port2 read, mem never ready
    cre     = 3'b100;
    m_rdata = 32'h0000_0055;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("wd_cyc%0d", k),
          {busy, grant, tevt, mem_if.re, c_rdy, c_err},
          {1'b1, 3'b100, 1'b0, 1'b1, 3'b000, 3'b000});
    end
    tick();
    chk("wd_fire", {busy, grant, tevt, mem_if.re, c_rdy, c_err},
        {1'b1, 3'b100, 1'b1, 1'b0, 3'b100, 3'b100});
    chk("wd_rdata2", c_rdata[2], AXO_MEM_ETIMEOUT);
    chk("wd_rdata0", c_rdata[0], 32'h0000_0055);
    tick();
    chk("wd_idle", {busy, grant, tevt}, {1'b0, 3'b000, 1'b0});
    cre = '0;

    // mem ready lands on the timeout cycle
    cre = 3'b001;
    for (int k = 0; k < 5; k++) tick();
    m_rdy = 1'b1;
    #1;
    chk("race", {grant, tevt, mem_if.re, c_rdy, c_err},
        {3'b001, 1'b0, 1'b1, 3'b001, 3'b000});
    tick();
    chk("race_done", {busy, grant}, {1'b0, 3'b000});
    cre   = '0;
    m_rdy = 1'b0;

    // reset in the middle of a transfer
    cre = 3'b011;
    tick();
    chk("mr_grant", grant, 3'b010);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_rst", {busy, grant, mem_if.re}, {1'b0, 3'b000, 1'b0});
    chk("mr_wdog", dut.wdog, 3'd0);
    rst = 1'b1;
    tick();
    chk("mr_rel", grant, 3'b001);
    cre = '0;
    tick();
    chk("mr_abort", {busy, grant, c_err}, {1'b0, 3'b000, 3'b000});

    mon = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axo_mem_rr_arbiter.md
Name: axo_mem_rr_arbiter

Overview:
- Registered round-robin arbiter that shares one axo_mem_bus target between several requesters.
- Fully synchronous, posedge only, with explicit IDLE/BUSY sequencing and a watchdog that ends transfers the target never completes.
- Sits in front of a shared MEM: a RAM, peripheral bridge, or one column of a crossbar.
- Grant is held for a whole transfer; rotation guarantees no requester starves.

Parameters:
- dlen, 32, data width; power of 2, >= 32.
- alen, 32, address width.
- cpus, 2, number of requester ports; >= 2.
- timeout, 255, cycles in BUSY without mem ready before forced error; 0 disables the watchdog.

Ports:
- clk  input  1  shared clock; all state on posedge.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- cpu_ports  modport axo_mem_bus.MEM  [cpus] x bus  requester side.
- mem_port  modport axo_mem_bus.CPU  bus  shared target side.
- grant  output  cpus  one-hot registered grant; 0 in IDLE.
- busy  output  1  1 while in BUSY.
- timeout_evt  output  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Request: req[i] = cpu_ports[i].re || cpu_ports[i].we.
- Reset (rst == 0 at posedge):
  - state = IDLE, grant = 0, last = 1 << (cpus-1), so port 0 wins first. wdog = 0.
  - mem_port re, we, asize, addr, wdata = 0.
  - All cpu ready and error = 0. rdata = mem_port.rdata (don't-care).
  - Reset mid-transfer abandons it; the MEM sees re/we drop in the next cycle.
- IDLE:
  - No req: stay in IDLE, last unchanged.
  - Any req: select the first requester after last in circular order (last+1 ... wrapping, then last itself). Register grant = last = selected, go to BUSY.
  - Latency: request first visible at edge N gives grant from cycle N+1.
- BUSY, combinational routing:
  - mem_port re/we/asize/addr/wdata = granted port's signals. Non-granted contributions are forced to 0.
  - Granted port: ready = mem_port.ready, error = mem_port.error.
  - Other ports: ready = 0, error = 0. rdata is broadcast to all ports.
- BUSY, exits:
  - Completion: mem_port.ready && req[granted] at a posedge -> IDLE, grant = 0.
  - One turnaround cycle between transfers is mandatory. Pipelined back-to-back transfers are out of scope.
  - Abort: granted port drops re and we -> IDLE, grant = 0, no error.
  - Requests from other ports in BUSY are ignored until IDLE.
- Watchdog (timeout > 0):
  - wdog counts up each BUSY cycle without mem_port.ready, and clears on entering BUSY.
  - When wdog == timeout:
    - mem_port re/we forced to 0 that cycle.
    - Granted port sees ready = 1, error = 1, rdata = AXO_MEM_ETIMEOUT.
    - timeout_evt = 1 for that cycle. Next state is IDLE.
  - If mem ready and the timeout fall in the same cycle, mem ready wins: normal completion, no timeout_evt.
  - wdog width = $clog2(timeout+1); it saturates and never wraps.
- Simultaneous events:
  - Completion and new requests in the same cycle: the new requests are arbitrated in the following IDLE cycle. Rotation pointer = last granted.
  - A single requester repeatedly requesting is granted every other cycle (IDLE/BUSY alternation).
- Invariants:
  - grant is one-hot or zero.
  - No mem_port.re/we while in IDLE.
  - ready is never asserted to a non-granted port.

Decomposition:
- Package axo_mem_pkg:
  - arbiter state enum {ARB_IDLE, ARB_BUSY}.
  - AXO_MEM_ETIMEOUT error code, alongside AXO_MEM_EMISSING.
  - Function rr_pick(req, last) returning a one-hot result.
- Sub-module axo_rr_pick: purely combinational rotate/priority-encode/rotate-back with parameter n.
  - Reused by future interrupt and DMA channel arbiters.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all req=1 -> grant=0, mem_port.re=we=0, all ready=0. First release edge -> grant=2'b01.
- Fairness (cpus=3, all req held, MEM ready=1 every cycle) -> grant sequence 001,0,010,0,100,0,001; each port completes exactly one transfer per 6 cycles.
- Routing: port1 writes addr=0x1000, wdata=0xDEADBEEF, asize=2 while port0 idle -> mem_port carries exactly those values. port0 ready stays 0. port1 ready mirrors the MEM.
- Watchdog (timeout=4, MEM ready stuck 0) -> on the 5th BUSY cycle the granted port sees ready=1, error=1, rdata=AXO_MEM_ETIMEOUT, timeout_evt pulses once, mem_port.re=0, then IDLE.
- Abort: port0 granted, drops re before ready -> next cycle IDLE. Pending port1 is granted one cycle later; no error anywhere.
- Mid-transfer reset: rst=0 during BUSY with MEM ready=0 -> next cycle grant=0, busy=0, wdog=0. After release, port0 wins again.
